// File: rtl/fetch_unit.sv
// IF stage: PC register, single-outstanding imem handshake, redirect/kill tracking, IF/ID register.
// Define FETCH_STATS_EN to add the redirect_count / kill_count statistics outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  AddressSelect,
  input  logic        IFID_flush,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] kill_count
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_pending, w_pending_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_hold, w_hold_nxt;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_step;
  logic [31:0] w_ld_data;
  logic        w_req, w_load, w_bubble, w_discard;

  assign w_redirect = (AddressSelect == 2'b01) | (AddressSelect == 2'b10);
  assign w_target   = (AddressSelect == 2'b01) ? branch_target : jump_target;
  assign w_pc_step  = r_pc + STEP;
  assign w_ld_data  = (r_state == S_HOLD) ? r_hold : imem_rdata;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending;
    w_kill_nxt    = r_kill;
    w_hold_nxt    = r_hold;
    w_req         = 1'b0;
    w_load        = 1'b0;
    w_bubble      = 1'b0;
    w_discard     = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req = !stall;
        if (w_redirect) begin
          w_bubble = 1'b1;
          if (!stall && !imem_ready) begin
            // Request already on the bus: keep the address, remember where to go.
            w_state_nxt   = S_WAIT;
            w_pending_nxt = w_target;
            w_kill_nxt    = 1'b1;
          end else begin
            w_pc_nxt  = w_target;
            w_discard = !stall && imem_ready;
          end
        end else if (!stall) begin
          if (imem_ready) begin
            w_load   = 1'b1;
            w_pc_nxt = w_pc_step;
          end else begin
            w_state_nxt = S_WAIT;
            w_bubble    = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (imem_ready) begin
          if (w_redirect || r_kill) begin
            w_discard   = 1'b1;
            w_bubble    = 1'b1;
            w_pc_nxt    = w_redirect ? w_target : r_pending;
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (stall) begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            w_load      = 1'b1;
            w_pc_nxt    = w_pc_step;
            w_state_nxt = S_REQ;
          end
        end else if (w_redirect) begin
          w_pending_nxt = w_target;
          w_kill_nxt    = 1'b1;
          w_bubble      = 1'b1;
        end else begin
          w_bubble = !stall;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_discard   = 1'b1;
          w_bubble    = 1'b1;
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (!stall) begin
          w_load      = 1'b1;
          w_pc_nxt    = w_pc_step;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // IF/ID update: a flush bubbles even a held or freshly loaded word.
  always_comb begin
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    if (w_bubble || IFID_flush) begin
      w_instr_nxt = 32'h0;
      w_valid_nxt = 1'b0;
    end else if (w_load) begin
      w_instr_nxt = w_ld_data;
      w_pc4_nxt   = w_pc_step;
      w_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_pc4     <= 32'h0;
      r_valid   <= 1'b0;
      r_pending <= 32'h0;
      r_kill    <= 1'b0;
      r_hold    <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_pc4     <= w_pc4_nxt;
      r_valid   <= w_valid_nxt;
      r_pending <= w_pending_nxt;
      r_kill    <= w_kill_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_redirect_cnt, r_kill_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_cnt <= 32'h0;
      r_kill_cnt     <= 32'h0;
    end else begin
      if (w_redirect) r_redirect_cnt <= r_redirect_cnt + 32'h1;
      if (w_discard)  r_kill_cnt     <= r_kill_cnt + 32'h1;
    end
  end
  assign redirect_count = r_redirect_cnt;
  assign kill_count     = r_kill_cnt;
`endif

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign pc_out     = r_pc;
  assign ifid_instr = r_instr;
  assign ifid_pc4   = r_pc4;
  assign ifid_valid = r_valid;

endmodule
